cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Parametrised run controller/checker that sits beside CPUTop in simulation and FPGA
//  bring-up. Sequences the core's reset, watches PC and register-file writeback to detect
//  a self-loop halt, and judges the program PASS/FAIL from a result register. Also flags a
//  cycle-budget TIMEOUT. Replaces fixed-delay, waveform-inspected runs with a
//  self-checking verdict.
// PARAMETERS
//  XLEN          32     data/PC width
//  RESET_CYCLES  4      cycles cpu_nrst is held low after start (>=1)
//  MAX_CYCLES    20000  RUN-cycle budget before TIMEOUT (>=1)
//  HALT_CYCLES   8      consecutive cycles with an unchanged PC that count as halt (>=2)
//  RESULT_REG    10     architectural register whose last written value is judged (1..31)
//  PASS_VALUE    0      RESULT_REG value meaning pass
//  CNT_W         32     width of cycle_count
// PORTS
//  sysclk       in   1      clock
//  rst          in   1      synchronous active-high reset
//  start        in   1      launch pulse (level-sampled)
//  pc           in   XLEN   CPU current PC
//  rf_we        in   1      register-file write enable
//  rf_waddr     in   5      register-file write address
//  rf_wdata     in   XLEN   register-file write data
//  cpu_nrst     out  1      active-low reset to CPUTop
//  busy         out  1      state is RESET or RUN
//  done         out  1      state is PASS, FAIL or TIMEOUT
//  pass         out  1      verdict PASS
//  fail         out  1      verdict FAIL
//  timeout      out  1      verdict TIMEOUT
//  result       out  XLEN   shadow copy of RESULT_REG
//  cycle_count  out  CNT_W  RUN cycles elapsed; saturates at all-ones
// BEHAVIOUR
//  - Reset (rst=1 at a sysclk edge, any state): state=IDLE, cpu_nrst=0, busy=done=pass=
//    fail=timeout=0, result=0, cycle_count=0, halt counter=0. Takes effect mid-run.
//  - States: IDLE, RESET, RUN, PASS, FAIL, TIMEOUT. All outputs are registered.
//  - IDLE: cpu_nrst=0. start=1 -> RESET; clear result, cycle_count, halt counter.
//  - RESET: cpu_nrst=0 for exactly RESET_CYCLES cycles, then -> RUN.
//    cpu_nrst=1 on the first RUN cycle.
//  - RUN: cpu_nrst=1; cycle_count increments every RUN cycle and saturates.
//    Shadow capture: rf_we=1 && rf_waddr==RESULT_REG -> result<=rf_wdata.
//    Writes to x0 and to other registers are ignored.
//    Halt counter: the first RUN cycle counts as a PC change (counter=0).
//    Thereafter, pc==pc_prev -> counter+1 (saturating); pc!=pc_prev -> counter=0.
//    Halt fires when the counter reaches HALT_CYCLES-1, i.e. the PC is stable for
//    HALT_CYCLES consecutive sampled cycles.
//    On halt -> PASS if the judged value == PASS_VALUE, else FAIL. The judged value is
//    the bypassed next value of result, so a RESULT_REG write in the halt cycle counts.
//    No halt, and cycle_count reaches MAX_CYCLES -> TIMEOUT.
//    Halt and timeout in the same cycle: halt wins.
//  - PASS/FAIL/TIMEOUT: sticky; the matching flag and done=1, cpu_nrst stays 1.
//    result and cycle_count freeze. start=1 -> RESET (relaunch) and clears the flags.
//  - start is ignored in RESET and RUN.
//  - pass, fail and timeout are mutually exclusive.
//  - Latency: start sampled at edge N -> busy=1 and cpu_nrst=0 after edge N.
//    First RUN cycle after edge N+RESET_CYCLES. Verdict visible after the edge that
//    detects halt.
// STRUCTURE
//  - Package cpu_mon_pkg: state encoding as localparam constants
//    (IDLE=0, RESET=1, RUN=2, PASS=3, FAIL=4, TIMEOUT=5), STATE_W=3.
//  - Sub-module cpu_mon_halt_detect (params XLEN, HALT_CYCLES): pc_prev register plus
//    stability counter, inputs clear/enable, output halt.
//  - Top: FSM, reset-hold counter, cycle counter, result shadow register.
// TESTING
//  1 rst mid-RUN (cycle 50) -> next cycle state=IDLE, cpu_nrst=0, all flags 0,
//    cycle_count=0.
//  2 start; program writes x10=0 then jumps to self at PC 0x40 -> cpu_nrst low 4 cycles,
//    then pass=1, done=1, result=0 after PC is stable 8 cycles; fail=timeout=0.
//  3 Same flow, x10=1 last write and x11=0 writes after it -> fail=1, result=1.
//  4 MAX_CYCLES=100, PC increments forever -> timeout=1 at cycle_count=100,
//    cpu_nrst stays 1.
//  5 PC stable 7 cycles, changes, then stable 8 -> no verdict after the first 7;
//    verdict after the second 8.
//  6 x10=5 written in the halt cycle with PASS_VALUE=5 -> pass=1. Then start from PASS
//    -> flags clear, RESET 4 cycles, new run.

Source files
------------

// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the CPU run monitor: state encoding and a small state helper.
package cpu_mon_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_RESET   = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN     = 3'd2;
    localparam logic [STATE_W-1:0] ST_PASS    = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAIL    = 3'd4;
    localparam logic [STATE_W-1:0] ST_TIMEOUT = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_RESET   = ST_RESET,
        S_RUN     = ST_RUN,
        S_PASS    = ST_PASS,
        S_FAIL    = ST_FAIL,
        S_TIMEOUT = ST_TIMEOUT
    } state_e;

    // A verdict state is terminal until the next launch.
    function automatic logic is_verdict(input state_e s);
        return (s == S_PASS) || (s == S_FAIL) || (s == S_TIMEOUT);
    endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Bundle between the run monitor (slave) and the CPU/bench side (master).
interface cpu_run_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic [XLEN-1:0]  pc;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             cpu_nrst;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [XLEN-1:0]  result;
    logic [CNT_W-1:0] cycle_count;

    modport slave (
        input  start, pc, rf_we, rf_waddr, rf_wdata,
        output cpu_nrst, busy, done, pass, fail, timeout, result, cycle_count
    );

    modport master (
        output start, pc, rf_we, rf_waddr, rf_wdata,
        input  cpu_nrst, busy, done, pass, fail, timeout, result, cycle_count
    );
endinterface

// File: rtl/cpu_mon_halt_detect.sv
// Self-loop detector: counts consecutive enabled cycles in which the PC did not change.
module cpu_mon_halt_detect #(
    parameter int XLEN        = 32,
    parameter int HALT_CYCLES = 8
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_halt
);
    localparam int HC_W = $clog2(HALT_CYCLES);
    localparam logic [HC_W-1:0] HALT_LAST = HC_W'(HALT_CYCLES - 1);

    logic [XLEN-1:0] r_pc_prev;
    logic            r_valid;
    logic [HC_W-1:0] r_cnt;
    logic [HC_W-1:0] w_cnt_next;

    // Without a valid previous PC the first enabled cycle counts as a change.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!r_valid || (i_pc != r_pc_prev)) begin
            w_cnt_next = '0;
        end else if (r_cnt != HALT_LAST) begin
            w_cnt_next = r_cnt + HC_W'(1);
        end
    end

    assign o_halt = i_enable && (w_cnt_next == HALT_LAST);

    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_pc_prev <= '0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
        end else if (i_enable) begin
            r_pc_prev <= i_pc;
            r_valid   <= 1'b1;
            r_cnt     <= w_cnt_next;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller/checker beside the CPU: sequences its reset, detects halt, judges the result.
module cpu_run_monitor #(
    parameter int XLEN         = 32,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 20000,
    parameter int HALT_CYCLES  = 8,
    parameter int RESULT_REG   = 10,
    parameter int PASS_VALUE   = 0,
    parameter int CNT_W        = 32
) (
    input  logic               sysclk,
    input  logic               rst,
    cpu_run_monitor_if.slave   bus
);
    import cpu_mon_pkg::*;

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [HOLD_W-1:0] r_hold;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_inc;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   w_result_next;
    logic              r_cpu_nrst;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_fail;
    logic              r_timeout;
    logic              w_launch;
    logic              w_run;
    logic              w_result_wr;
    logic              w_halt;
    logic              w_timeout;
    logic              w_judge_pass;

    assign w_run       = (r_state == S_RUN);
    assign w_launch    = bus.start && ((r_state == S_IDLE) || is_verdict(r_state));
    assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);
    assign w_timeout   = w_run && (w_count_inc >= CNT_W'(MAX_CYCLES));

    assign w_result_wr = w_run && bus.rf_we && (bus.rf_waddr != 5'd0)
                         && (bus.rf_waddr == 5'(RESULT_REG));

    always_comb begin
        w_result_next = r_result;
        if (w_launch) begin
            w_result_next = '0;
        end else if (w_result_wr) begin
            w_result_next = bus.rf_wdata;
        end
    end

    // Judge the bypassed value so a result write in the halt cycle is honoured.
    assign w_judge_pass = (w_result_next == XLEN'(PASS_VALUE));

    cpu_mon_halt_detect #(
        .XLEN        (XLEN),
        .HALT_CYCLES (HALT_CYCLES)
    ) u_halt (
        .clk      (sysclk),
        .srst     (rst),
        .i_clear  (!w_run),
        .i_enable (w_run),
        .i_pc     (bus.pc),
        .o_halt   (w_halt)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_next = S_RESET;
            end
            S_RESET: begin
                if (r_hold == HOLD_LAST) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_halt) begin
                    w_state_next = w_judge_pass ? S_PASS : S_FAIL;
                end else if (w_timeout) begin
                    w_state_next = S_TIMEOUT;
                end
            end
            S_PASS, S_FAIL, S_TIMEOUT: begin
                if (bus.start) w_state_next = S_RESET;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_count    <= '0;
            r_result   <= '0;
            r_cpu_nrst <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_result <= w_result_next;

            if (w_launch) begin
                r_count <= '0;
            end else if (w_run) begin
                r_count <= w_count_inc;
            end

            if (r_state != S_RESET) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_LAST) begin
                r_hold <= r_hold + HOLD_W'(1);
            end

            // Flags follow the state being entered so they line up with it.
            r_cpu_nrst <= (w_state_next == S_RUN) || is_verdict(w_state_next);
            r_busy     <= (w_state_next == S_RESET) || (w_state_next == S_RUN);
            r_done     <= is_verdict(w_state_next);
            r_pass     <= (w_state_next == S_PASS);
            r_fail     <= (w_state_next == S_FAIL);
            r_timeout  <= (w_state_next == S_TIMEOUT);
        end
    end

    assign bus.cpu_nrst    = r_cpu_nrst;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.fail        = r_fail;
    assign bus.timeout     = r_timeout;
    assign bus.result      = r_result;
    assign bus.cycle_count = r_count;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a cycle table for one full run plus hand sequences.
module tb_cpu_run_monitor;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    // Flag vector order: {cpu_nrst, busy, done, pass, fail, timeout}
    localparam logic [5:0] F_IDLE = 6'b000000;
    localparam logic [5:0] F_RST  = 6'b010000;
    localparam logic [5:0] F_RUN  = 6'b110000;
    localparam logic [5:0] F_PASS = 6'b101100;
    localparam logic [5:0] F_FAIL = 6'b101010;
    localparam logic [5:0] F_TMO  = 6'b101001;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    always #5 sysclk = ~sysclk;

    cpu_run_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_a ();
    cpu_run_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_b ();

    assign bus_a.start    = start;
    assign bus_a.pc       = pc;
    assign bus_a.rf_we    = rf_we;
    assign bus_a.rf_waddr = rf_waddr;
    assign bus_a.rf_wdata = rf_wdata;
    assign bus_b.start    = start;
    assign bus_b.pc       = pc;
    assign bus_b.rf_we    = rf_we;
    assign bus_b.rf_waddr = rf_waddr;
    assign bus_b.rf_wdata = rf_wdata;

    cpu_run_monitor #(
        .XLEN(XLEN), .RESET_CYCLES(4), .MAX_CYCLES(100), .HALT_CYCLES(8),
        .RESULT_REG(10), .PASS_VALUE(0), .CNT_W(CNT_W)
    ) dut_a (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus_a)
    );

    cpu_run_monitor #(
        .XLEN(XLEN), .RESET_CYCLES(4), .MAX_CYCLES(100), .HALT_CYCLES(8),
        .RESULT_REG(10), .PASS_VALUE(5), .CNT_W(CNT_W)
    ) dut_b (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus_b)
    );

    typedef struct {
        logic        st;
        logic [31:0] pc;
        logic        we;
        logic [31:0] wd;
        logic [5:0]  fl;
        logic [31:0] res;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic s, input logic [31:0] p, input logic we,
                                input logic [31:0] wd, input logic [5:0] fl,
                                input logic [31:0] res, input logic [31:0] cnt);
        vec_t v;
        v.st = s; v.pc = p; v.we = we; v.wd = wd; v.fl = fl; v.res = res; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [5:0] flags_a();
        return {bus_a.cpu_nrst, bus_a.busy, bus_a.done, bus_a.pass, bus_a.fail, bus_a.timeout};
    endfunction

    function automatic logic [5:0] flags_b();
        return {bus_b.cpu_nrst, bus_b.busy, bus_b.done, bus_b.pass, bus_b.fail, bus_b.timeout};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [31:0] p, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        start = s; pc = p; rf_we = we; rf_waddr = wa; rf_wdata = wd;
    endtask

    task automatic run(input logic [31:0] p, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
        drive(1'b0, p, we, wa, wd);
        step();
    endtask

    // Start pulse then four held-reset cycles; returns in the first RUN cycle.
    task automatic launch(input string tag);
        drive(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk({tag, "_launch_flags"}, flags_a(), F_RST);
        chk({tag, "_launch_cnt"}, bus_a.cycle_count, 0);
        chk({tag, "_launch_res"}, bus_a.result, 0);
        start = 1'b0;
        repeat (4) step();
        chk({tag, "_first_run"}, flags_a(), F_RUN);
        $display("launch %s: cpu released", tag);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        chk("por_flags_a", flags_a(), F_IDLE);
        chk("por_flags_b", flags_b(), F_IDLE);
        chk("por_res", bus_a.result, 0);
        chk("por_cnt", bus_a.cycle_count, 0);
        rst = 1'b0;
        step();
        chk("idle_hold", flags_a(), F_IDLE);

        // Full run, one row per clock: x10=3, x10=0, self-loop at 0x40 -> pass.
        vecs[0]  = mk(1'b1, 32'h0,  1'b0, 0, F_RST, 0, 0);
        vecs[1]  = mk(1'b0, 32'h0,  1'b0, 0, F_RST, 0, 0);
        vecs[2]  = mk(1'b1, 32'h0,  1'b0, 0, F_RST, 0, 0);
        vecs[3]  = mk(1'b0, 32'h0,  1'b0, 0, F_RST, 0, 0);
        vecs[4]  = mk(1'b0, 32'h0,  1'b0, 0, F_RUN, 0, 0);
        vecs[5]  = mk(1'b0, 32'h0,  1'b1, 3, F_RUN, 3, 1);
        vecs[6]  = mk(1'b0, 32'h4,  1'b0, 0, F_RUN, 3, 2);
        vecs[7]  = mk(1'b0, 32'h8,  1'b1, 0, F_RUN, 0, 3);
        vecs[8]  = mk(1'b0, 32'h40, 1'b0, 0, F_RUN, 0, 4);
        for (int i = 9; i < 15; i++) begin
            vecs[i] = mk(1'b0, 32'h40, 1'b0, 0, F_RUN, 0, 32'(i - 4));
        end
        vecs[15] = mk(1'b0, 32'h40, 1'b0, 0, F_PASS, 0, 11);
        vecs[16] = mk(1'b0, 32'h40, 1'b1, 9, F_PASS, 0, 11);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].st, vecs[i].pc, vecs[i].we, 5'd10, vecs[i].wd);
            step();
            chk($sformatf("tbl%0d_flags", i), flags_a(), vecs[i].fl);
            chk($sformatf("tbl%0d_res", i), bus_a.result, vecs[i].res);
            chk($sformatf("tbl%0d_cnt", i), bus_a.cycle_count, vecs[i].cnt);
            $display("vec %0d: pc=%08h flags=%06b result=%0d count=%0d",
                     i, vecs[i].pc, flags_a(), bus_a.result, bus_a.cycle_count);
        end
        chk("tbl_b_fail", flags_b(), F_FAIL);

        // Last x10 write is 1, later writes to x11 and x0 must be ignored.
        launch("fail");
        run(32'h0, 1'b1, 5'd10, 32'd1);
        run(32'h4, 1'b1, 5'd11, 32'd0);
        run(32'h8, 1'b1, 5'd0,  32'd0);
        run(32'hC, 1'b0, 5'd0,  32'd0);
        repeat (7) run(32'h40, 1'b0, 5'd0, 32'd0);
        chk("fail_pre_halt", flags_a(), F_RUN);
        run(32'h40, 1'b0, 5'd0, 32'd0);
        chk("fail_flags", flags_a(), F_FAIL);
        chk("fail_res", bus_a.result, 1);
        chk("fail_cnt", bus_a.cycle_count, 12);
        $display("run fail: result=%0d count=%0d", bus_a.result, bus_a.cycle_count);

        // Stable 7, change, then stable 8.
        launch("stab");
        repeat (7) run(32'h100, 1'b0, 5'd0, 32'd0);
        chk("stab_after7", flags_a(), F_RUN);
        repeat (7) run(32'h104, 1'b0, 5'd0, 32'd0);
        chk("stab_second7", flags_a(), F_RUN);
        run(32'h104, 1'b0, 5'd0, 32'd0);
        chk("stab_verdict", flags_a(), F_PASS);
        chk("stab_cnt", bus_a.cycle_count, 15);
        $display("run stab: flags=%06b count=%0d", flags_a(), bus_a.cycle_count);

        // PC never settles: timeout after 100 RUN cycles; start in RUN is ignored.
        launch("tmo");
        for (int i = 0; i < 99; i++) begin
            drive((i == 30), 32'h200 + 32'(4 * i), 1'b0, 5'd0, 32'd0);
            step();
        end
        chk("tmo_pre_flags", flags_a(), F_RUN);
        chk("tmo_pre_cnt", bus_a.cycle_count, 99);
        run(32'h1000, 1'b0, 5'd0, 32'd0);
        chk("tmo_flags", flags_a(), F_TMO);
        chk("tmo_cnt", bus_a.cycle_count, 100);
        run(32'h1004, 1'b0, 5'd0, 32'd0);
        run(32'h1008, 1'b0, 5'd0, 32'd0);
        chk("tmo_sticky", flags_a(), F_TMO);
        chk("tmo_frozen", bus_a.cycle_count, 100);
        $display("run tmo: flags=%06b count=%0d", flags_a(), bus_a.cycle_count);

        // Reset asserted mid-run at cycle 50.
        launch("rst");
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 32'h300 + 32'(4 * i), (i == 10), 5'd10, 32'd7);
            step();
        end
        chk("rst_pre_cnt", bus_a.cycle_count, 50);
        chk("rst_pre_res", bus_a.result, 7);
        rst = 1'b1;
        step();
        chk("rst_flags_a", flags_a(), F_IDLE);
        chk("rst_flags_b", flags_b(), F_IDLE);
        chk("rst_cnt", bus_a.cycle_count, 0);
        chk("rst_res", bus_a.result, 0);
        rst = 1'b0;
        run(32'h400, 1'b0, 5'd0, 32'd0);
        chk("rst_stay_idle", flags_a(), F_IDLE);
        $display("run rst: flags=%06b", flags_a());

        // x10=5 written in the halt cycle: B (pass value 5) passes, A fails.
        launch("byp");
        run(32'h10, 1'b1, 5'd10, 32'd1);
        repeat (7) run(32'h40, 1'b0, 5'd0, 32'd0);
        run(32'h40, 1'b1, 5'd10, 32'd5);
        chk("byp_b_flags", flags_b(), F_PASS);
        chk("byp_b_res", bus_b.result, 5);
        chk("byp_a_flags", flags_a(), F_FAIL);
        $display("run byp: a=%06b b=%06b result=%0d", flags_a(), flags_b(), bus_b.result);

        // Relaunch from PASS.
        drive(1'b1, 32'h0, 1'b0, 5'd0, 32'd0);
        step();
        chk("rel_flags", flags_b(), F_RST);
        chk("rel_res", bus_b.result, 0);
        chk("rel_cnt", bus_b.cycle_count, 0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rel_hold%0d", i), flags_b(), F_RST);
        end
        step();
        chk("rel_run", flags_b(), F_RUN);
        repeat (8) run(32'h80, 1'b0, 5'd0, 32'd0);
        chk("rel_a_pass", flags_a(), F_PASS);
        chk("rel_b_fail", flags_b(), F_FAIL);
        chk("rel_cnt_end", bus_b.cycle_count, 8);
        $display("run rel: a=%06b b=%06b count=%0d", flags_a(), flags_b(), bus_b.cycle_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
